// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (loader, CPU data, CPU fetch) and RAM-side signals around mem_port_arbiter.
// slave is the arbiter's view; master is the surrounding system (requesters plus RAM macro).
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          l_req;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_done;
  logic          l_gnt;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [DW-1:0] f_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          cpu_stall;
  logic          boot_done;

  modport slave (
    input  l_req, l_addr, l_wdata, l_done,
    input  d_req, d_we, d_addr, d_wdata,
    input  f_req, f_addr,
    input  mem_rdata,
    output l_gnt, d_gnt, d_rvalid, d_rdata,
    output f_gnt, f_rvalid, f_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output cpu_stall, boot_done
  );

  modport master (
    output l_req, l_addr, l_wdata, l_done,
    output d_req, d_we, d_addr, d_wdata,
    output f_req, f_addr,
    output mem_rdata,
    input  l_gnt, d_gnt, d_rvalid, d_rdata,
    input  f_gnt, f_rvalid, f_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  cpu_stall, boot_done
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between loader (boot only), CPU data and CPU fetch (data wins in RUN).
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 3
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic {LOAD, RUN} state_t;
  typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_D = 2'd1, TAG_F = 2'd2} tag_t;

  state_t state_q, state_d;
  tag_t   tag_q, tag_d;
  logic   lGnt, dGnt, fGnt;
  logic   fPriority;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] starveCnt_q, starveCnt_d;

  // Counts consecutive RUN cycles in which fetch asked and lost; any fetch grant or idle fetch clears it.
  always_comb begin
    starveCnt_d = '0;
    if (state_q == RUN && bus.f_req && !fGnt) begin
      starveCnt_d = (starveCnt_q == STARVE_LIM) ? starveCnt_q : starveCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starveCnt_q <= '0;
    else      starveCnt_q <= starveCnt_d;
  end

  assign fPriority = (starveCnt_q == STARVE_LIM);
`else
  assign fPriority = 1'b0;
`endif

  // Grants are forced low while reset is held so nothing reaches the RAM.
  always_comb begin
    state_d = state_q;
    lGnt    = 1'b0;
    dGnt    = 1'b0;
    fGnt    = 1'b0;
    unique case (state_q)
      LOAD: begin
        lGnt = rst & bus.l_req;
        if (bus.l_done) state_d = RUN;
      end
      RUN: begin
        if (rst) begin
          if (fPriority && bus.f_req) fGnt = 1'b1;
          else if (bus.d_req)         dGnt = 1'b1;
          else if (bus.f_req)         fGnt = 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    tag_d = TAG_NONE;
    if (dGnt && !bus.d_we) tag_d = TAG_D;
    else if (fGnt)         tag_d = TAG_F;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      tag_q   <= TAG_NONE;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
    end
  end

  assign bus.l_gnt = lGnt;
  assign bus.d_gnt = dGnt;
  assign bus.f_gnt = fGnt;

  assign bus.mem_en    = lGnt | dGnt | fGnt;
  assign bus.mem_we    = lGnt | (dGnt & bus.d_we);
  assign bus.mem_addr  = lGnt ? bus.l_addr :
                         dGnt ? bus.d_addr :
                         fGnt ? bus.f_addr : '0;
  assign bus.mem_wdata = lGnt ? bus.l_wdata :
                         dGnt ? bus.d_wdata : '0;

  // Read data is steered by the tag captured when the read was issued one cycle earlier.
  assign bus.d_rvalid = (tag_q == TAG_D);
  assign bus.f_rvalid = (tag_q == TAG_F);
  assign bus.d_rdata  = (tag_q == TAG_D) ? bus.mem_rdata : '0;
  assign bus.f_rdata  = (tag_q == TAG_F) ? bus.mem_rdata : '0;

  assign bus.cpu_stall = (bus.f_req & ~fGnt) | (bus.d_req & ~dGnt);
  assign bus.boot_done = (state_q == RUN);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous 256x8 RAM between three requesters: program loader (L), CPU data load/store (D) and CPU instruction fetch (F).
- Sits between the CPU core and the memory macro.
- Sequences a boot phase (loader only), then a run phase with D-over-F fixed priority.
- Routes the 1-cycle-latency read data back to the requester that issued the read, and drives a CPU stall when either CPU port is denied.

Parameters:
AW, 8, address width (memory depth 2^AW)
DW, 8, data width
STARVE_MAX, 3, consecutive fetch denials before a forced fetch grant (used only with ARB_STARVE_GUARD_EN)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
l_req  input  1  loader write request
l_addr  input  AW  loader write address
l_wdata  input  DW  loader write data
l_done  input  1  one-cycle pulse: program load complete
l_gnt  output  1  loader write accepted this cycle
d_req  input  1  CPU data request
d_we  input  1  1=store, 0=load
d_addr  input  AW  data address
d_wdata  input  DW  store data
d_gnt  output  1  data request accepted this cycle
d_rvalid  output  1  load data valid
d_rdata  output  DW  load data
f_req  input  1  fetch request
f_addr  input  AW  fetch address (PC)
f_gnt  output  1  fetch accepted this cycle
f_rvalid  output  1  fetch data valid
f_rdata  output  DW  fetched byte
mem_en  output  1  RAM access enable
mem_we  output  1  RAM write enable
mem_addr  output  AW  RAM address
mem_wdata  output  DW  RAM write data
mem_rdata  input  DW  RAM read data, valid 1 cycle after a read issue
cpu_stall  output  1  (f_req & ~f_gnt) | (d_req & ~d_gnt)
boot_done  output  1  high in RUN state

Behaviour:
- FSM, 2 states:
  - LOAD: reset state. Only L is served; l_gnt = l_req; f_gnt = d_gnt = 0.
  - RUN: l_gnt = 0 always.
  - LOAD -> RUN on l_done (registered). l_done with l_req in the same cycle: the write is still granted.
  - RUN is terminal until reset.
- RUN arbitration, combinational, same cycle as request: d_req wins, otherwise f_req. At most one grant per cycle.
- Memory side is combinational from the granted request:
  - mem_en = any gnt; mem_we = l_gnt | (d_gnt & d_we).
  - mem_addr / mem_wdata come from the winner.
  - All memory outputs are 0 when there is no grant.
- Read return:
  - Registered 2-bit owner tag {NONE, D, F}, set on the granted read (d load or fetch).
  - Next cycle: matching rvalid = 1; rdata = mem_rdata; non-matching rdata = 0.
  - Stores and loader writes produce no rvalid.
- Back-to-back reads are fully pipelined: a grant may be issued in the same cycle as the previous read's rvalid.
- Reset values:
  - State LOAD, tag NONE; all rvalid, boot_done and starve counter 0.
  - Grants are 0 during reset.
  - Reset mid-read drops the pending return (no rvalid after reset release).
- Requesters hold req/addr/wdata stable until gnt. Deasserting req before gnt is legal (request withdrawn).
- cpu_stall is purely combinational; it is 1 in LOAD whenever f_req or d_req is asserted.

Optional Feature:
ARB_STARVE_GUARD_EN
- Defined:
  - Saturating counter (width $clog2(STARVE_MAX+1)) counts consecutive RUN cycles with f_req & ~f_gnt.
  - When it equals STARVE_MAX, F beats D for one cycle.
  - Counter clears on f_gnt or on ~f_req.
- Undefined: no counter; D strictly beats F; fetch can starve indefinitely under continuous d_req.

Test Plan:
- Reset, then loader writes 0xA5 @0x00 and 0x3C @0x01, then l_done -> l_gnt=1 each write; f_req during LOAD gives f_gnt=0, cpu_stall=1; boot_done=1 the cycle after l_done.
- RUN, f_req @0x01 only -> f_gnt=1, mem_addr=0x01, next cycle f_rvalid=1, f_rdata=0x3C, d_rvalid=0.
- RUN, f_req @0x00 and d_req load @0x01 in the same cycle -> d_gnt=1, f_gnt=0, cpu_stall=1; next cycle d_rdata=0x3C and f_gnt=1; following cycle f_rdata=0xA5.
- Store d_we=1 0x77 @0x10, then load @0x10 next cycle -> mem_we=1 only in the first cycle; d_rvalid one cycle after the load grant with 0x77; no rvalid for the store.
- ARB_STARVE_GUARD_EN, STARVE_MAX=3, continuous d_req and f_req -> f_gnt=1 on the 4th cycle, then D wins for 3 more cycles; without the macro f_gnt stays 0 throughout.
- Assert rst on the cycle after a fetch grant -> no f_rvalid after release, state LOAD, all outputs 0.
